hdmi_power_sequencer: RTL and testbench
=======================================

HDMI_POWER_SEQUENCER -- requirements
Module: hdmi_power_sequencer

Interface
REQ-001 SHALL have parameter PD_DELAY, default 16: cycles between transmitter power-up and pixel-domain reset release (legal range 1..65535).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 32: cycles between pixel reset release and ready_o (legal range 1..65535).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1000: maximum cycles to wait for PLL lock (legal range 1..65535).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n_i, input, 1 bit: asynchronous active-low reset, driven by the synchronized reset stage.
REQ-006 SHALL have port enable_i, input, 1 bit: request to bring up the video output.
REQ-007 SHALL have port pll_locked_i, input, 1 bit: pixel PLL lock, already synchronous to clk_i.
REQ-008 SHALL have port tx_pd_n_o, output, 1 bit: HDMI transmitter power-down, active-low.
REQ-009 SHALL have port pixel_reset_n_o, output, 1 bit: active-low reset to the pixel pipeline.
REQ-010 SHALL have port ready_o, output, 1 bit: sequence complete, video path live.
REQ-011 SHALL have port fault_o, output, 1 bit: lock timeout occurred.

Function
REQ-012 SHALL implement states IDLE, WAIT_LOCK, POWER_UP, SETTLE, RUN, FAULT in one registered state machine.
REQ-013 SHALL drive all outputs from flops decoded from the state register: tx_pd_n_o=1 in POWER_UP/SETTLE/RUN; pixel_reset_n_o=1 in SETTLE/RUN; ready_o=1 in RUN only; fault_o=1 in FAULT only; all others 0.
REQ-014 IDLE -> WAIT_LOCK on the first edge where enable_i=1.
REQ-015 WAIT_LOCK -> POWER_UP on the first edge where pll_locked_i=1; the wait counter clears on entry to WAIT_LOCK.
REQ-016 POWER_UP SHALL last exactly PD_DELAY cycles, then -> SETTLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then -> RUN.
REQ-018 In POWER_UP, SETTLE or RUN, pll_locked_i=0 SHALL force -> WAIT_LOCK on the next edge, dropping tx_pd_n_o, pixel_reset_n_o and ready_o together.
REQ-019 enable_i=0 in any state SHALL force -> IDLE on the next edge; this has priority over lock loss, timeout and counter expiry.
REQ-020 Lock loss SHALL have priority over counter expiry when both occur on the same edge.
REQ-021 FAULT SHALL hold until enable_i=0, then -> IDLE; pll_locked_i is ignored in FAULT.
REQ-022 A single shared down-counter SHALL be sized to the largest parameter and reloaded on every state entry; it never wraps, holding at 0.

Reset
REQ-023 reset_n_i=0 SHALL asynchronously force state IDLE, counter 0 and all four outputs 0, independent of clk_i.
REQ-024 Reset release SHALL take effect synchronously; the first transition is possible on the first clk_i edge with reset_n_i=1.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence with no partial output state retained.

Configuration
REQ-026 Macro HDMI_POWER_SEQ_TIMEOUT_EN SHALL, when defined, make WAIT_LOCK -> FAULT once LOCK_TIMEOUT cycles elapse without lock; lock seen on the expiry edge wins.
REQ-027 When HDMI_POWER_SEQ_TIMEOUT_EN is undefined, WAIT_LOCK SHALL wait indefinitely, FAULT SHALL be unreachable, and fault_o SHALL be tied to 0.

Verification
REQ-028 PD_DELAY=4, SETTLE_CYCLES=8, enable_i=1, lock high at cycle 10 -> tx_pd_n_o rises cycle 11, pixel_reset_n_o cycle 15, ready_o cycle 23.
REQ-029 In RUN, pll_locked_i low for 1 cycle -> all three outputs low the next cycle; after lock returns, the full 4+8 sequence repeats.
REQ-030 enable_i falls in SETTLE at the same edge lock drops -> IDLE (not WAIT_LOCK); outputs 0 next cycle.
REQ-031 Macro defined, LOCK_TIMEOUT=20, lock never asserted -> fault_o=1 after 20 cycles in WAIT_LOCK; enable_i=0 clears it the next cycle.
REQ-032 Macro undefined, lock withheld 5000 cycles -> fault_o stays 0 and the FSM stays in WAIT_LOCK.
REQ-033 reset_n_i pulsed low between clock edges during POWER_UP -> outputs 0 immediately; sequence restarts from IDLE after release.

Source files
------------

// File: rtl/hdmi_power_sequencer.sv
// -----------------------------------------------------------------------------
// hdmi_power_sequencer
//
// Brings up an HDMI video output in a fixed order:
//   1. Wait for the pixel PLL to lock.
//   2. Power up the transmitter and hold the pixel pipeline in reset for
//      PD_DELAY cycles.
//   3. Release the pixel pipeline reset and let it settle for SETTLE_CYCLES.
//   4. Report ready.
// Losing lock from any powered state drops back to waiting for lock.
// Dropping enable from any state returns to idle.
//
// Optional feature (compile-time macro HDMI_POWER_SEQ_TIMEOUT_EN):
//   defined   - waiting for lock gives up after LOCK_TIMEOUT cycles and enters
//               FAULT, which raises fault_o until enable_i is dropped.
//   undefined - the lock wait is unbounded and fault_o is tied low.
//
// Parameters:
//   PD_DELAY      cycles from transmitter power-up to pixel reset release
//   SETTLE_CYCLES cycles from pixel reset release to ready_o
//   LOCK_TIMEOUT  maximum lock wait (timeout build only)
//
// Ports:
//   clk_i            single clock
//   reset_n_i        asynchronous active-low reset (from the reset synchronizer)
//   enable_i         request to bring up the video output
//   pll_locked_i     pixel PLL lock, synchronous to clk_i
//   tx_pd_n_o        transmitter power-down, active-low (1 = powered)
//   pixel_reset_n_o  pixel pipeline reset, active-low (1 = running)
//   ready_o          sequence complete, video path live
//   fault_o          lock timeout occurred
// -----------------------------------------------------------------------------
module hdmi_power_sequencer #(
  parameter int PD_DELAY      = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int LOCK_TIMEOUT  = 1000
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic enable_i,
  input  logic pll_locked_i,
  output logic tx_pd_n_o,
  output logic pixel_reset_n_o,
  output logic ready_o,
  output logic fault_o
);

  // Largest of the three delays; the shared counter must be able to hold it.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  localparam int MAX_DELAY = max3(PD_DELAY, SETTLE_CYCLES, LOCK_TIMEOUT);
  localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_POWER_UP  = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               cnt_zero_s;
  logic               tx_pd_n_nxt_s;
  logic               pixel_reset_n_nxt_s;
  logic               ready_nxt_s;
  logic               fault_nxt_s;

  // Counter value loaded on entry to a state. The counter runs from
  // (duration - 1) down to 0, so a state with a loaded value of N-1 lasts
  // exactly N cycles.
  function automatic logic [CNT_W-1:0] load_value(input state_t s);
    logic [CNT_W-1:0] v;
    case (s)
`ifdef HDMI_POWER_SEQ_TIMEOUT_EN
      ST_WAIT_LOCK: v = CNT_W'(LOCK_TIMEOUT - 1);
`else
      ST_WAIT_LOCK: v = {CNT_W{1'b0}};
`endif
      ST_POWER_UP:  v = CNT_W'(PD_DELAY - 1);
      ST_SETTLE:    v = CNT_W'(SETTLE_CYCLES - 1);
      default:      v = {CNT_W{1'b0}};
    endcase
    return v;
  endfunction

  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Priority: enable low, then lock loss, then expiry.
  always_comb begin
    state_nxt_s = state_r;
    if (!enable_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (pll_locked_i) begin
            state_nxt_s = ST_POWER_UP;
          end else begin
`ifdef HDMI_POWER_SEQ_TIMEOUT_EN
            // Lock seen on the expiry edge is handled above and wins.
            if (cnt_zero_s) begin
              state_nxt_s = ST_FAULT;
            end else begin
              state_nxt_s = ST_WAIT_LOCK;
            end
`else
            state_nxt_s = ST_WAIT_LOCK;
`endif
          end
        end
        ST_POWER_UP: begin
          if (!pll_locked_i) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else if (cnt_zero_s) begin
            state_nxt_s = ST_SETTLE;
          end else begin
            state_nxt_s = ST_POWER_UP;
          end
        end
        ST_SETTLE: begin
          if (!pll_locked_i) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else if (cnt_zero_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_SETTLE;
          end
        end
        ST_RUN: begin
          if (!pll_locked_i) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FAULT: begin
          // Lock is ignored here; only enable low leaves FAULT.
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Shared down-counter: reload on any state change, otherwise count to 0 and hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = load_value(state_nxt_s);
    end else if (!cnt_zero_s) begin
      cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Output decode from the next state, so the output flops change on the
  // same edge as the state register and never lag it.
  always_comb begin
    tx_pd_n_nxt_s       = 1'b0;
    pixel_reset_n_nxt_s = 1'b0;
    ready_nxt_s         = 1'b0;
    fault_nxt_s         = 1'b0;
    case (state_nxt_s)
      ST_POWER_UP: begin
        tx_pd_n_nxt_s = 1'b1;
      end
      ST_SETTLE: begin
        tx_pd_n_nxt_s       = 1'b1;
        pixel_reset_n_nxt_s = 1'b1;
      end
      ST_RUN: begin
        tx_pd_n_nxt_s       = 1'b1;
        pixel_reset_n_nxt_s = 1'b1;
        ready_nxt_s         = 1'b1;
      end
      ST_FAULT: begin
        fault_nxt_s = 1'b1;
      end
      default: begin
        tx_pd_n_nxt_s = 1'b0;
      end
    endcase
  end

  // Counter and output flops; reset clears everything with no clock needed.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r           <= {CNT_W{1'b0}};
      tx_pd_n_o       <= 1'b0;
      pixel_reset_n_o <= 1'b0;
      ready_o         <= 1'b0;
    end else begin
      cnt_r           <= cnt_nxt_s;
      tx_pd_n_o       <= tx_pd_n_nxt_s;
      pixel_reset_n_o <= pixel_reset_n_nxt_s;
      ready_o         <= ready_nxt_s;
    end
  end

`ifdef HDMI_POWER_SEQ_TIMEOUT_EN
  // Fault flag flop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fault_o <= 1'b0;
    end else begin
      fault_o <= fault_nxt_s;
    end
  end
`else
  // Without the timeout FAULT cannot be reached, so the flag is constant.
  logic unused_fault_s;
  assign unused_fault_s = fault_nxt_s;
  assign fault_o        = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hdmi_power_sequencer
//
// Directed bench for hdmi_power_sequencer with PD_DELAY=4, SETTLE_CYCLES=8,
// LOCK_TIMEOUT=20. The stimulus process pushes the expected output vector
// {tx_pd_n, pixel_reset_n, ready, fault} for a given clock edge number into a
// queue; the monitor samples the outputs on each falling edge and compares
// every queued entry tagged with the edge just passed.
// -----------------------------------------------------------------------------
module tb_hdmi_power_sequencer;

  localparam int PD  = 4;
  localparam int ST  = 8;
  localparam int LTO = 20;

  logic clk;
  logic rst_n;
  logic enable;
  logic lock;
  logic tx_pd_n;
  logic pix_rst_n;
  logic ready;
  logic fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  hdmi_power_sequencer #(
    .PD_DELAY      (PD),
    .SETTLE_CYCLES (ST),
    .LOCK_TIMEOUT  (LTO)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .enable_i        (enable),
    .pll_locked_i    (lock),
    .tx_pd_n_o       (tx_pd_n),
    .pixel_reset_n_o (pix_rst_n),
    .ready_o         (ready),
    .fault_o         (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after posedge number n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at the edge just passed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks = checks + 1;
      if (mon_e.cyc != cyc) begin
        failures = failures + 1;
        $display("FAIL %s: expectation for edge %0d reached at edge %0d", mon_e.name, mon_e.cyc, cyc);
      end else if ({tx_pd_n, pix_rst_n, ready, fault} !== mon_e.exp) begin
        failures = failures + 1;
        $display("FAIL %s @edge %0d: got %b required %b", mon_e.name, cyc,
                 {tx_pd_n, pix_rst_n, ready, fault}, mon_e.exp);
      end
    end
  end

  task automatic expect_at(input int c, input logic [3:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.exp  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Advance to 1 time unit after posedge number c.
  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n  = 1'b0;
    enable = 1'b0;
    lock   = 1'b0;

    // Reset state, then basic bring-up: lock sampled at edge 6.
    step_to(3);
    expect_at(3, 4'b0000, "reset_state");
    rst_n  = 1'b1;
    enable = 1'b1;
    expect_at(4, 4'b0000, "wait_lock");
    for (int k = 5; k <= 20; k++) begin
      if (k < 6)       expect_at(k, 4'b0000, "bringup_wait");
      else if (k < 10) expect_at(k, 4'b1000, "bringup_power_up");
      else if (k < 18) expect_at(k, 4'b1100, "bringup_settle");
      else             expect_at(k, 4'b1110, "bringup_run");
    end
    step_to(5);
    lock = 1'b1;
    step_to(20);

    // One-cycle lock loss in RUN, then full resequence.
    for (int k = 20; k <= 35; k++) begin
      if (k == 20)      expect_at(k, 4'b1110, "lockloss_run");
      else if (k == 21) expect_at(k, 4'b0000, "lockloss_drop");
      else if (k < 26)  expect_at(k, 4'b1000, "lockloss_power_up");
      else if (k < 34)  expect_at(k, 4'b1100, "lockloss_settle");
      else              expect_at(k, 4'b1110, "lockloss_run_again");
    end
    lock = 1'b0;
    step_to(21);
    lock = 1'b1;
    step_to(35);

    // Enable drop from RUN, restart, then enable+lock drop together in SETTLE.
    expect_at(36, 4'b0000, "disable_from_run");
    enable = 1'b0;
    step_to(36);
    enable = 1'b1;
    expect_at(37, 4'b0000, "restart_wait");
    for (int k = 38; k <= 41; k++) expect_at(k, 4'b1000, "restart_power_up");
    for (int k = 42; k <= 44; k++) expect_at(k, 4'b1100, "restart_settle");
    step_to(44);
    enable = 1'b0;
    lock   = 1'b0;
    expect_at(45, 4'b0000, "enable_over_lockloss");
    step_to(45);
    enable = 1'b1;
    lock   = 1'b1;
    // From IDLE two edges are needed to reach POWER_UP; from WAIT_LOCK only one.
    expect_at(46, 4'b0000, "went_idle_not_wait");
    expect_at(47, 4'b1000, "idle_restart_power_up");

    // Lock loss on the same edge as POWER_UP expiry (edge 51).
    for (int k = 48; k <= 50; k++) expect_at(k, 4'b1000, "expiry_power_up");
    expect_at(51, 4'b0000, "lockloss_over_expiry");
    step_to(50);
    lock = 1'b0;
    step_to(51);
    lock = 1'b1;
    expect_at(52, 4'b1000, "reload_power_up");

    // Asynchronous reset between edges during POWER_UP.
    step_to(53);
    #1;
    rst_n = 1'b0;
    expect_at(53, 4'b0000, "async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    expect_at(54, 4'b0000, "post_reset_wait");
    for (int k = 55; k <= 58; k++) expect_at(k, 4'b1000, "post_reset_power_up");
    expect_at(59, 4'b1100, "post_reset_settle");
    step_to(59);

    // Lock withheld in WAIT_LOCK.
    lock = 1'b0;
    w = 60;
    expect_at(w, 4'b0000, "enter_wait_lock");
`ifdef HDMI_POWER_SEQ_TIMEOUT_EN
    expect_at(w + 18, 4'b0000, "timeout_not_yet");
    expect_at(w + 19, 4'b0000, "timeout_last_wait");
    expect_at(w + 20, 4'b0001, "timeout_fault");
    step_to(w + 20);
    lock = 1'b1;
    expect_at(w + 21, 4'b0001, "fault_ignores_lock");
    expect_at(w + 22, 4'b0001, "fault_holds");
    step_to(w + 22);
    enable = 1'b0;
    expect_at(w + 23, 4'b0000, "fault_cleared");
    step_to(w + 23);
`else
    for (int k = 1; k <= 4; k++) expect_at(w + 1000 * k, 4'b0000, "no_timeout_wait");
    expect_at(w + 4999, 4'b0000, "no_timeout_end");
    step_to(w + 4999);
    lock = 1'b1;
    // Still in WAIT_LOCK: one edge with lock reaches POWER_UP.
    expect_at(w + 5000, 4'b1000, "still_wait_lock");
    step_to(w + 5000);
`endif

    step_to(cyc + 3);
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
